// File: rtl/sipo_shift_receiver_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
package sipo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } sipo_state_t;

   localparam int SIPO_DEFAULT_WIDTH = 8;

endpackage : sipo_pkg

// File: rtl/sipo_shift_receiver_if.sv
// Parallel output port of the receiver: word, valid and ready.
interface sipo_shift_receiver_if #(
   parameter int WIDTH = sipo_pkg::SIPO_DEFAULT_WIDTH
);
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;

   // Receiver side: presents words and observes the consumer's ready.
   modport master (output parallel_out, output out_valid, input out_ready);
   // Consumer side: takes words and drives ready.
   modport slave  (input parallel_out, input out_valid, output out_ready);
endinterface : sipo_shift_receiver_if

// File: rtl/sipo_shift_receiver_out_buffer.sv
// Single-entry valid/ready holding register for completed words.
// A word arriving while the entry is occupied and not being drained is
// dropped and flagged with a one-cycle overrun pulse.
module sipo_out_buffer #(
   parameter int WIDTH = sipo_pkg::SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             word_valid_i,
   input  logic [WIDTH-1:0] word_i,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] parallel_out_o,
   output logic             out_valid_o,
   output logic             overrun_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // Next-state: drain on handshake, accept a new word when the entry frees up.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
      if (word_valid_i) begin
         if (!valid_q || out_ready_i) begin
            data_d  = word_i;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Holding register and overrun pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign parallel_out_o = data_q;
   assign out_valid_o    = valid_q;
   assign overrun_o      = overrun_q;

endmodule : sipo_out_buffer

// File: rtl/sipo_shift_receiver.sv
// MSB-first deserializer: frames words on frame_start, qualifies bits with
// enable, and hands completed words to a single-entry output buffer.
module sipo_shift_receiver
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  serial_in,
   input  logic                  frame_start,
   sipo_shift_receiver_if.master out_if,
   output logic [WIDTH-1:0]      shift_reg,
   output logic [CW-1:0]         bit_count,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   sipo_state_t      state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic             frame_err_q, frame_err_d;
   logic             word_done;
   logic [WIDTH-1:0] shifted;

   // Register contents after shifting the current bit into the LSB.
   assign shifted = {shift_q[WIDTH-2:0], serial_in};

   // Next-state: frame start, bit capture, restart and word completion.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      count_d     = count_q;
      frame_err_d = 1'b0;
      word_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && frame_start) begin
               shift_d = shifted;
               count_d = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (enable) begin
               shift_d = shifted;
               if (frame_start) begin
                  // Restart wins over completion: this bit is a new MSB.
                  count_d     = CW'(1);
                  frame_err_d = 1'b1;
               end else if (count_q == LAST_COUNT) begin
                  count_d   = '0;
                  word_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, shift register, bit counter and restart pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         frame_err_q <= frame_err_d;
      end
   end

   logic [WIDTH-1:0] buf_data;
   logic             buf_valid;

   sipo_out_buffer #(.WIDTH(WIDTH)) u_out_buffer (
      .clk            (clk),
      .reset_n        (reset_n),
      .word_valid_i   (word_done),
      .word_i         (shifted),
      .out_ready_i    (out_if.out_ready),
      .parallel_out_o (buf_data),
      .out_valid_o    (buf_valid),
      .overrun_o      (overrun)
   );

   assign out_if.parallel_out = buf_data;
   assign out_if.out_valid    = buf_valid;
   assign shift_reg           = shift_q;
   assign bit_count           = count_q;
   assign frame_err           = frame_err_q;

endmodule : sipo_shift_receiver
